// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master write state enum.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi4_lite_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_WRITE  = 2'd1,
    M_WAIT_B = 2'd2
  } m_axi_write_states;

endpackage

// File: rtl/axi4_lite_write_master_if.sv
// AXI4-Lite write channels (AW, W, B) bundled for master/slave connection.
// Latency: none, wires only.
// Backpressure: standard valid/ready on AW, W and B.
// Ports: master drives aw*/w* payload+valid and bready; slave drives awready, wready, bresp, bvalid.
interface axi4_lite_write_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi4_lite_write_master.sv
// Turns a one-cycle core store request into a single AXI4-Lite write (AW+W jointly, then B).
// Latency: 4 cycles minimum from request to write_done when the slave readies AW/W a cycle after valid.
// Backpressure: holds valids/bready until handshake; stalls the core until B or timeout abort.
// Ports: clk, rst (sync, active-high); core side write_req/addr/data/strb in, stall/write_done/write_err out;
//        m_axi is the AXI4-Lite write master modport.
module axi4_lite_write_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_req,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [3:0]            write_strb,
  output logic                  stall,
  output logic                  write_done,
  output logic                  write_err,
  axi4_lite_write_master_if.master m_axi
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  m_axi_write_states     state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [3:0]            strb_q;
  logic [CNT_W-1:0]      cnt_q;

  logic aw_w_hs;
  logic b_hs;
  logic timeout;

  // AXI outputs depend only on registered state so there is no input-to-output path.
  assign m_axi.awaddr  = addr_q;
  assign m_axi.wdata   = data_q;
  assign m_axi.wstrb   = strb_q;
  assign m_axi.awvalid = (state == M_WRITE);
  assign m_axi.wvalid  = (state == M_WRITE);
  assign m_axi.bready  = (state == M_WAIT_B);

  // AW and W are only ever accepted together; an AW-only ready is ignored.
  assign aw_w_hs = (state == M_WRITE) && m_axi.awready && m_axi.wready;
  assign b_hs    = (state == M_WAIT_B) && m_axi.bvalid;
  // A B handshake on the last allowed cycle wins over the abort.
  assign timeout = (state != M_IDLE) && (cnt_q == CNT_MAX) && !b_hs;

  // Gated by rst so a reset in WAIT_B never reports a response.
  assign write_done = !rst && (b_hs || timeout);
  assign write_err  = !rst && (b_hs ? (m_axi.bresp != AXI_RESP_OKAY) : timeout);

  // Released on the finishing cycle so the core advances together with write_done.
  assign stall = (state != M_IDLE) ? !(b_hs || timeout) : write_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= M_IDLE;
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
      cnt_q  <= '0;
    end else begin
      // Saturating count of cycles spent outside IDLE.
      if (state != M_IDLE && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      case (state)
        M_IDLE: begin
          if (write_req) begin
            addr_q <= write_addr;
            data_q <= write_data;
            strb_q <= write_strb;
            cnt_q  <= '0;
            state  <= M_WRITE;
          end
        end
        M_WRITE: begin
          if (timeout) begin
            state <= M_IDLE;
          end else if (aw_w_hs) begin
            state <= M_WAIT_B;
          end
        end
        M_WAIT_B: begin
          if (b_hs || timeout) begin
            state <= M_IDLE;
          end
        end
        default: state <= M_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_write_master.sv
// Directed bench for axi4_lite_write_master: the bench plays the core and the AXI slave cycle by cycle.
// Latency: n/a.
// Backpressure: slave readiness is scripted per cycle.
module tb_axi4_lite_write_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_req;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic [3:0]  write_strb;
  logic        stall;
  logic        write_done;
  logic        write_err;

  int tests_run = 0;
  int tests_failed = 0;

  axi4_lite_write_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi4_lite_write_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .write_req  (write_req),
    .write_addr (write_addr),
    .write_data (write_data),
    .write_strb (write_strb),
    .stall      (stall),
    .write_done (write_done),
    .write_err  (write_err),
    .m_axi      (axi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge, where new inputs are applied.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic slave(input logic awr, input logic wr, input logic bv, input logic [1:0] br);
    axi.awready = awr;
    axi.wready  = wr;
    axi.bvalid  = bv;
    axi.bresp   = br;
  endtask

  task automatic req(input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    write_req  = r;
    write_addr = a;
    write_data = d;
    write_strb = s;
  endtask

  initial begin
    rst = 1'b1;
    req(1'b0, 32'h0, 32'h0, 4'h0);
    slave(1'b0, 1'b0, 1'b0, 2'b00);
    step();
    step();
    rst = 1'b0;

    // Reset state
    mid();
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_done", write_done, 0);
    chk("rst_err", write_err, 0);
    chk("rst_awaddr", axi.awaddr, 0);
    chk("rst_wdata", axi.wdata, 0);
    chk("rst_wstrb", axi.wstrb, 0);
    chk("rst_stall", stall, 0);
    step();

    // Single store, slave readies one cycle after valid
    req(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    mid();
    chk("t1_c0_stall", stall, 1);
    chk("t1_c0_awvalid", axi.awvalid, 0);
    step();
    req(1'b0, 32'h0, 32'h0, 4'h0);
    mid();
    chk("t1_c1_awvalid", axi.awvalid, 1);
    chk("t1_c1_wvalid", axi.wvalid, 1);
    chk("t1_c1_awaddr", axi.awaddr, 32'h0000_1000);
    chk("t1_c1_wdata", axi.wdata, 32'hDEAD_BEEF);
    chk("t1_c1_wstrb", axi.wstrb, 4'hF);
    chk("t1_c1_stall", stall, 1);
    step();
    slave(1'b1, 1'b1, 1'b0, 2'b00);
    mid();
    chk("t1_c2_stall", stall, 1);
    chk("t1_c2_done", write_done, 0);
    step();
    slave(1'b0, 1'b0, 1'b1, 2'b00);
    mid();
    chk("t1_c3_bready", axi.bready, 1);
    chk("t1_c3_done", write_done, 1);
    chk("t1_c3_err", write_err, 0);
    chk("t1_c3_stall", stall, 0);
    step();
    slave(1'b0, 1'b0, 1'b0, 2'b00);
    mid();
    chk("t1_c4_done", write_done, 0);
    chk("t1_c4_bready", axi.bready, 0);
    chk("t1_c4_awvalid", axi.awvalid, 0);
    step();

    // WREADY withheld for 5 cycles while AWREADY=1; mid-transaction input changes ignored
    req(1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF);
    step();
    for (int i = 1; i <= 5; i++) begin
      slave(1'b1, 1'b0, 1'b0, 2'b00);
      if (i == 3) req(1'b1, 32'h0000_FFFF, 32'hFFFF_FFFF, 4'h1);
      else req(1'b0, 32'h0, 32'h0, 4'h0);
      mid();
      chk($sformatf("t2_c%0d_awvalid", i), axi.awvalid, 1);
      chk($sformatf("t2_c%0d_wvalid", i), axi.wvalid, 1);
      chk($sformatf("t2_c%0d_awaddr", i), axi.awaddr, 32'h0000_2000);
      chk($sformatf("t2_c%0d_wdata", i), axi.wdata, 32'h1234_5678);
      step();
    end
    req(1'b0, 32'h0, 32'h0, 4'h0);
    slave(1'b1, 1'b1, 1'b0, 2'b00);
    mid();
    chk("t2_c6_awvalid", axi.awvalid, 1);
    chk("t2_c6_bready", axi.bready, 0);
    step();
    slave(1'b0, 1'b0, 1'b1, 2'b00);
    mid();
    chk("t2_c7_done", write_done, 1);
    chk("t2_c7_err", write_err, 0);
    step();
    slave(1'b0, 1'b0, 1'b0, 2'b00);
    mid();
    chk("t2_c8_done", write_done, 0);
    chk("t2_c8_bready", axi.bready, 0);
    step();

    // SLVERR response with partial strobe
    req(1'b1, 32'h0000_3000, 32'hA5A5_A5A5, 4'b0011);
    step();
    req(1'b0, 32'h0, 32'h0, 4'h0);
    slave(1'b1, 1'b1, 1'b0, 2'b00);
    mid();
    chk("t3_c1_wstrb", axi.wstrb, 4'b0011);
    step();
    slave(1'b0, 1'b0, 1'b1, 2'b10);
    mid();
    chk("t3_c2_done", write_done, 1);
    chk("t3_c2_err", write_err, 1);
    step();
    slave(1'b0, 1'b0, 1'b0, 2'b00);
    mid();
    chk("t3_c3_done", write_done, 0);
    chk("t3_c3_err", write_err, 0);
    chk("t3_c3_stall", stall, 0);
    chk("t3_c3_bready", axi.bready, 0);
    step();

    // No BVALID ever: abort on cycle 8 with TIMEOUT_CYCLES=8
    req(1'b1, 32'h0000_4000, 32'h4444_4444, 4'hF);
    step();
    req(1'b0, 32'h0, 32'h0, 4'h0);
    step();
    slave(1'b1, 1'b1, 1'b0, 2'b00);
    step();
    slave(1'b0, 1'b0, 1'b0, 2'b00);
    for (int c = 3; c <= 7; c++) begin
      mid();
      chk($sformatf("t4_c%0d_done", c), write_done, 0);
      chk($sformatf("t4_c%0d_bready", c), axi.bready, 1);
      step();
    end
    mid();
    chk("t4_c8_done", write_done, 1);
    chk("t4_c8_err", write_err, 1);
    chk("t4_c8_stall", stall, 0);
    step();
    mid();
    chk("t4_c9_awvalid", axi.awvalid, 0);
    chk("t4_c9_wvalid", axi.wvalid, 0);
    chk("t4_c9_bready", axi.bready, 0);
    chk("t4_c9_done", write_done, 0);
    chk("t4_c9_stall", stall, 0);
    step();

    // Back-to-back stores
    req(1'b1, 32'h0000_0010, 32'h1111_1111, 4'hF);
    step();
    req(1'b0, 32'h0, 32'h0, 4'h0);
    slave(1'b1, 1'b1, 1'b0, 2'b00);
    mid();
    chk("t5_a_awaddr", axi.awaddr, 32'h0000_0010);
    chk("t5_a_wdata", axi.wdata, 32'h1111_1111);
    step();
    slave(1'b0, 1'b0, 1'b1, 2'b00);
    mid();
    chk("t5_a_done", write_done, 1);
    step();
    slave(1'b0, 1'b0, 1'b0, 2'b00);
    req(1'b1, 32'h0000_0014, 32'h2222_2222, 4'hF);
    mid();
    chk("t5_b_req_stall", stall, 1);
    step();
    req(1'b0, 32'h0, 32'h0, 4'h0);
    slave(1'b1, 1'b1, 1'b0, 2'b00);
    mid();
    chk("t5_b_awvalid", axi.awvalid, 1);
    chk("t5_b_awaddr", axi.awaddr, 32'h0000_0014);
    chk("t5_b_wdata", axi.wdata, 32'h2222_2222);
    step();
    slave(1'b0, 1'b0, 1'b1, 2'b00);
    mid();
    chk("t5_b_done", write_done, 1);
    chk("t5_b_err", write_err, 0);
    step();
    slave(1'b0, 1'b0, 1'b0, 2'b00);

    // Reset while in WAIT_B, then a fresh store
    req(1'b1, 32'h0000_5000, 32'h5555_5555, 4'hF);
    step();
    req(1'b0, 32'h0, 32'h0, 4'h0);
    slave(1'b1, 1'b1, 1'b0, 2'b00);
    step();
    slave(1'b0, 1'b0, 1'b0, 2'b00);
    mid();
    chk("t6_waitb_bready", axi.bready, 1);
    step();
    rst = 1'b1;
    mid();
    chk("t6_rst_done", write_done, 0);
    step();
    rst = 1'b0;
    slave(1'b0, 1'b0, 1'b1, 2'b00);
    mid();
    chk("t6_post_bready", axi.bready, 0);
    chk("t6_post_awvalid", axi.awvalid, 0);
    chk("t6_post_done", write_done, 0);
    chk("t6_post_stall", stall, 0);
    step();
    slave(1'b0, 1'b0, 1'b0, 2'b00);
    req(1'b1, 32'h0000_6000, 32'h6666_6666, 4'hC);
    step();
    req(1'b0, 32'h0, 32'h0, 4'h0);
    slave(1'b1, 1'b1, 1'b0, 2'b00);
    mid();
    chk("t6_new_awaddr", axi.awaddr, 32'h0000_6000);
    chk("t6_new_wstrb", axi.wstrb, 4'hC);
    step();
    slave(1'b0, 1'b0, 1'b1, 2'b00);
    mid();
    chk("t6_new_done", write_done, 1);
    chk("t6_new_err", write_err, 0);
    step();
    slave(1'b0, 1'b0, 1'b0, 2'b00);
    mid();
    chk("t6_new_idle_done", write_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
